sync_fifo_fwft: RTL and testbench

Synchronous single-clock FIFO with first-word-fall-through (FWFT) read semantics. Main storage is a single-port RAM, which allows one read or one write per cycle. A 2-entry prefetch buffer sits in front of the RAM so the head word is always presented on rdata_o without a read request. Used as a generic elastic buffer between producer and consumer blocks in the same clock domain.

---
 rtl/sync_fifo_fwft.sv | 158 +++++++++++++++
 tb/tb_sync_fifo_fwft.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_fwft.sv
// ---------------------------------------------------------------------------
// sync_fifo_fwft
//
// Single-clock FIFO with first-word-fall-through reads. Bulk storage is a
// single-port RAM (one read or one write per cycle). A 2-entry prefetch
// buffer in front of it always holds the head word, so rdata_o is valid
// whenever rvalid_o is high and no read request is needed to see it.
//
// Ports
//   clk       clock, all state changes on the rising edge
//   rst       asynchronous active-high reset
//   ren_i     pop the head word (ignored while empty_o=1)
//   rdata_o   head word, valid while rvalid_o=1; holds the last popped
//             word once the buffer runs dry
//   empty_o   prefetch buffer holds no word
//   rvalid_o  !empty_o
//   wen_i     push wdata_i (ignored while full_o=1)
//   wdata_i   write data
//   full_o    count_o == FIFO_DEPTH
//   count_o   words held in RAM + buffer + in-flight RAM read
// ---------------------------------------------------------------------------
module sync_fifo_fwft #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ren_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  empty_o,
    output logic                  rvalid_o,
    input  logic                  wen_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  full_o,
    output logic [ADDR_WIDTH:0]   count_o
);

    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(FIFO_DEPTH);

    // Main storage
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   ram_cnt;
    logic [ADDR_WIDTH:0]   count;

    // RAM read data register; rd_pend marks that it holds a word which must
    // enter the buffer at the coming edge.
    logic [DATA_WIDTH-1:0] ram_q;
    logic                  rd_pend;

    // Prefetch buffer: buf0 is the head, buf1 the next word
    logic [DATA_WIDTH-1:0] buf0;
    logic [DATA_WIDTH-1:0] buf1;
    logic [1:0]            buf_cnt;
    logic [DATA_WIDTH-1:0] buf0_n;
    logic [DATA_WIDTH-1:0] buf1_n;
    logic [1:0]            buf_cnt_n;

    // Per-cycle decisions
    logic                  push;
    logic                  pop;
    logic [1:0]            buf_left;
    logic                  direct;
    logic                  ram_wr;
    logic                  ram_rd;
    logic                  in_vld;
    logic [DATA_WIDTH-1:0] in_data;

    assign empty_o  = (buf_cnt == 2'd0);
    assign rvalid_o = !empty_o;
    assign full_o   = (count == DEPTH_L);
    assign count_o  = count;
    assign rdata_o  = buf0;

    // Accept/route decisions. Flags come straight from registered state, so
    // ren_i/wen_i never reach full_o or empty_o combinationally.
    always_comb begin
        pop      = ren_i && !empty_o;
        push     = wen_i && !full_o;
        buf_left = buf_cnt - {1'b0, pop};
        // A write may skip the RAM only when nothing older is in the RAM or
        // on its way out of it, otherwise order would break.
        direct   = push && (ram_cnt == '0) && !rd_pend && (buf_left < 2'd2);
        ram_wr   = push && !direct;
        // Prefetch only when the buffer can still absorb the word once it
        // arrives, counting the one already in flight. Writes own the port.
        ram_rd   = !ram_wr && (ram_cnt != '0) &&
                   ((buf_left + {1'b0, rd_pend}) < 2'd2);
        // At most one word enters the buffer per cycle: direct writes
        // require no read in flight.
        in_vld   = rd_pend || direct;
        in_data  = rd_pend ? ram_q : wdata_i;
    end

    // Next buffer contents: pop shifts buf1 forward, then the incoming word
    // lands in the first free slot. Popping the last word leaves buf0 as is
    // so the stale word stays visible.
    always_comb begin
        buf0_n    = buf0;
        buf1_n    = buf1;
        buf_cnt_n = buf_left;
        if (pop && (buf_cnt == 2'd2)) begin
            buf0_n = buf1;
        end
        if (in_vld) begin
            if (buf_left == 2'd0) begin
                buf0_n = in_data;
            end else begin
                buf1_n = in_data;
            end
            buf_cnt_n = buf_left + 2'd1;
        end
    end

    // Control state and the visible head word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ram_cnt <= '0;
            count   <= '0;
            rd_pend <= 1'b0;
            buf_cnt <= 2'd0;
            buf0    <= '0;
        end else begin
            if (ram_wr) begin
                wr_ptr  <= wr_ptr + ADDR_WIDTH'(1);
                ram_cnt <= ram_cnt + (ADDR_WIDTH+1)'(1);
            end else if (ram_rd) begin
                rd_ptr  <= rd_ptr + ADDR_WIDTH'(1);
                ram_cnt <= ram_cnt - (ADDR_WIDTH+1)'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
                2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
                default: count <= count;
            endcase
            rd_pend <= ram_rd;
            buf_cnt <= buf_cnt_n;
            buf0    <= buf0_n;
        end
    end

    // Data-only storage: single-port RAM plus the second buffer slot, whose
    // content is only meaningful while buf_cnt says so.
    always_ff @(posedge clk) begin
        if (ram_wr) begin
            mem[wr_ptr] <= wdata_i;
        end
        if (ram_rd) begin
            ram_q <= mem[rd_ptr];
        end
        buf1 <= buf1_n;
    end

endmodule

// File: tb/tb_sync_fifo_fwft.sv
module tb_sync_fifo_fwft;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ren_i = 1'b0;
    logic [DW-1:0] rdata_o;
    logic          empty_o;
    logic          rvalid_o;
    logic          wen_i = 1'b0;
    logic [DW-1:0] wdata_i = '0;
    logic          full_o;
    logic [AW:0]   count_o;

    sync_fifo_fwft #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .ren_i    (ren_i),
        .rdata_o  (rdata_o),
        .empty_o  (empty_o),
        .rvalid_o (rvalid_o),
        .wen_i    (wen_i),
        .wdata_i  (wdata_i),
        .full_o   (full_o),
        .count_o  (count_o)
    );

    always #5 clk = ~clk;

    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] exp_q[$];
    int            mcount = 0;
    logic [DW-1:0] last_pop = '0;
    int            wfree = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: samples on the falling edge, compares what the
    // DUT presents against the model, then books the transfer that the next
    // rising edge will perform.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            mcount   = 0;
            last_pop = '0;
            wfree    = 0;
        end else begin
            bit wr_ok;
            bit rd_ok;
            check("count", int'(count_o), mcount);
            check("full", int'(full_o), int'(mcount == DEPTH));
            check("rvalid_vs_empty", int'(rvalid_o), int'(!empty_o));
            if (mcount == 0) check("empty_when_no_data", int'(empty_o), 1);
            // After several cycles without writes the prefetch must have
            // caught up, so stored data has to be visible.
            if (wfree >= 3 && mcount > 0) check("prefetch_delivers", int'(rvalid_o), 1);
            if (rvalid_o) begin
                if (exp_q.size() == 0) check("head_available", int'(exp_q.size() > 0), 1);
                else check("head_data", int'(rdata_o), int'(exp_q[0]));
            end else begin
                check("stale_data", int'(rdata_o), int'(last_pop));
            end
            wr_ok = wen_i && (mcount < DEPTH);
            rd_ok = ren_i && rvalid_o && (exp_q.size() > 0);
            if (rd_ok) last_pop = exp_q.pop_front();
            mcount = mcount + int'(wr_ok) - int'(rd_ok);
            wfree  = wen_i ? 0 : wfree + 1;
        end
    end

    // One stimulus cycle: drive, record an accepted write, wait past the edge.
    task automatic step(input bit w, input logic [DW-1:0] d, input bit r);
        wen_i   = w;
        wdata_i = d;
        ren_i   = r;
        if (w && mcount < DEPTH) exp_q.push_back(d);
        @(posedge clk);
        #1;
        wen_i = 1'b0;
        ren_i = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 64 && mcount != 0; k++) step(1'b0, '0, 1'b1);
        check({name, "_drained_count"}, int'(count_o), 0);
        check({name, "_drained_empty"}, int'(empty_o), 1);
    endtask

    initial begin
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_count", int'(count_o), 0);
        check("reset_empty", int'(empty_o), 1);
        check("reset_rvalid", int'(rvalid_o), 0);
        check("reset_full", int'(full_o), 0);
        check("reset_rdata", int'(rdata_o), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Bypass into empty FIFO, then pop
        step(1'b1, 8'd1, 1'b0);
        check("bypass_empty", int'(empty_o), 0);
        check("bypass_rdata", int'(rdata_o), 1);
        check("bypass_count", int'(count_o), 1);
        step(1'b0, '0, 1'b1);
        check("pop_empty", int'(empty_o), 1);
        check("pop_count", int'(count_o), 0);

        // Streaming
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 8'(i), i > 1);
            check("stream_count_le2", int'(count_o <= 2), 1);
        end
        drain("stream");

        // Pop on empty with simultaneous write
        step(1'b1, 8'd2, 1'b1);
        check("emptyrd_rdata", int'(rdata_o), 2);
        check("emptyrd_empty", int'(empty_o), 0);
        check("emptyrd_count", int'(count_o), 1);
        drain("emptyrd");

        // Fill past capacity
        for (int v = 3; v <= 15; v++) begin
            step(1'b1, 8'(v), 1'b0);
            if (v == 9) check("fill_not_full_at7", int'(full_o), 0);
            if (v >= 10) begin
                check("fill_full", int'(full_o), 1);
                check("fill_count", int'(count_o), DEPTH);
            end
        end
        // Push + pop while full: write dropped, oldest word leaves
        step(1'b1, 8'd99, 1'b1);
        check("fullpp_count", int'(count_o), DEPTH - 1);
        check("fullpp_head", int'(rdata_o), 4);
        drain("fill");

        // Asynchronous reset in the middle of traffic
        for (int v = 20; v < 25; v++) step(1'b1, 8'(v), 1'b0);
        check("pre_reset_count", int'(count_o), 5);
        #2 rst = 1'b1;
        #1;
        check("async_rst_count", int'(count_o), 0);
        check("async_rst_empty", int'(empty_o), 1);
        check("async_rst_rvalid", int'(rvalid_o), 0);
        check("async_rst_full", int'(full_o), 0);
        check("async_rst_rdata", int'(rdata_o), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 8'd42, 1'b0);
        check("post_rst_rdata", int'(rdata_o), 42);
        check("post_rst_count", int'(count_o), 1);
        drain("post_rst");

        // Randomized traffic alternating between fill-heavy and drain-heavy
        for (int i = 0; i < 3000; i++) begin
            int wp;
            int rp;
            case ((i / 150) % 3)
                0:       begin wp = 85; rp = 25; end
                1:       begin wp = 25; rp = 85; end
                default: begin wp = 60; rp = 60; end
            endcase
            step($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < rp);
        end
        drain("random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
